core_mem_resp: RTL and testbench
================================

// Module: core_mem_resp
// PURPOSE
//  Memory-side responder for the MCQ-generated memory-cycle timing strobes.
//  Emulates a destructive-read core store: DL1/DL2 open the read, XT senses the word into
//  the buffer, JG presents the result, XL restores (read) or writes new data (write).
//  Sits between the timing generator and the CPU data path; one word per cycle envelope.
// PARAMETERS
//  AW     12   address width; array depth = 2**AW words
//  DW     16   data word width
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst_n     in   1   synchronous reset, active low
//  i_SZMNC   in   1   memory-cycle envelope, active low (0 = cycle in progress)
//  i_SZMDL1  in   1   read-current phase 1 strobe
//  i_SZMDL2  in   1   read-current phase 2 strobe
//  i_SZMXT   in   1   sense/select strobe
//  i_SZMJG   in   1   result strobe
//  i_SZMXL   in   1   write/restore strobe
//  i_W       in   1   1 = write cycle (store i_WD), 0 = read cycle (restore sensed word)
//  i_MA      in   AW  word address, sampled at DL1
//  i_WD      in   DW  write data, sampled at XL
//  o_RD      out  DW  sensed word
//  o_RDV     out  1   one-cycle pulse: o_RD valid
//  o_BUSY    out  1   1 while state != IDLE
//  o_SEQERR  out  1   one-cycle pulse: strobe out of order or cycle aborted
//  o_PERR    out  1   one-cycle parity-error pulse (tied 0 without MEM_PARITY_EN)
// BEHAVIOUR
//  - Strobes arrive clk-synchronous. Each has a 1-cycle delayed copy; rise = cur & !prev.
//    Actions on rise detected at edge N take effect at edge N+1 (registered outputs).
//  - Reset (rst_n=0 at posedge): state=IDLE, dl2_seen=0, all delayed copies=0, o_RD=0,
//    o_RDV=0, o_BUSY=0, o_SEQERR=0, o_PERR=0. Array contents NOT cleared.
//    Reset mid-cycle abandons the access; a word already sensed stays destroyed (0).
//  - States: IDLE -> ADDR -> SENSE -> HOLD -> DONE -> IDLE.
//    IDLE : DL1 rise with i_SZMNC=0 -> ADDR; latch addr=i_MA, wr=i_W; dl2_seen=0.
//    ADDR : DL2 rise -> dl2_seen=1. XT rise with dl2_seen=1 -> SENSE; mb=array[addr];
//           array[addr]=0 (destructive read). XT rise with dl2_seen=0 -> SEQERR, stay.
//    SENSE: JG rise -> HOLD; o_RD=mb; o_RDV=1 for exactly one cycle.
//    HOLD : XL rise -> DONE; array[addr] = wr ? i_WD : mb.
//    DONE : i_SZMNC rise -> IDLE (normal completion, no error).
//  - i_SZMNC rise in ADDR/SENSE/HOLD: abort -> IDLE, SEQERR pulse; no restore performed.
//  - Any strobe rise not expected in the current state (incl. DL1 outside IDLE, any
//    strobe in IDLE except DL1): ignored, SEQERR pulse, state unchanged.
//  - Simultaneous rises: i_SZMNC rise has priority; else the expected strobe advances
//    and any other simultaneous rise additionally pulses SEQERR.
//  - DL1 rise while i_SZMNC=1: ignored, SEQERR pulse.
//  - Read latency: JG rises at edge N -> o_RDV=1, o_RD valid during cycle after edge N+1.
//  - o_RD holds its value until the next JG action; o_RDV/o_SEQERR/o_PERR are pulses.
// CONFIGURATION
//  MEM_PARITY_EN defined: array is DW+1 bits; restore stores odd parity of stored data;
//    at SENSE the parity is checked; mismatch -> o_PERR pulse coincident with o_RDV.
//    Sensed data is still delivered and restored with freshly computed parity.
//  MEM_PARITY_EN undefined: array DW bits, o_PERR tied 0, no parity logic.
// TESTING
//  1 Write cycle: DL1(MA=0x005,W=1),DL2,XT,JG,XL(WD=0xBEEF),SZMNC^ -> o_RDV once, DONE->IDLE, no SEQERR.
//  2 Read-back: read cycle at 0x005 -> o_RD=0xBEEF with o_RDV 1 cycle after JG rise; word restored, 2nd read 0xBEEF.
//  3 Abort: read 0x005, raise i_SZMNC after JG before XL -> SEQERR pulse, IDLE; next read returns 0x0000.
//  4 Order error: XT rise before DL2 in ADDR -> SEQERR pulse, state ADDR; then DL2,XT proceed normally.
//  5 Reset in HOLD -> all outputs 0, o_BUSY=0; following full write/read cycle to 0x00A passes.
//  6 MEM_PARITY_EN: force array parity bit of 0x005 wrong, read -> o_PERR and o_RDV same cycle, o_RD correct.

Source files
------------

// File: rtl/core_mem_resp_if.sv
// Strobe/data bundle between the memory-cycle timing generator (master) and the
// core-store responder (slave).
interface core_mem_resp_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          i_SZMNC;
    logic          i_SZMDL1;
    logic          i_SZMDL2;
    logic          i_SZMXT;
    logic          i_SZMJG;
    logic          i_SZMXL;
    logic          i_W;
    logic [AW-1:0] i_MA;
    logic [DW-1:0] i_WD;
    logic [DW-1:0] o_RD;
    logic          o_RDV;
    logic          o_BUSY;
    logic          o_SEQERR;
    logic          o_PERR;

    modport master (
        output i_SZMNC, i_SZMDL1, i_SZMDL2, i_SZMXT, i_SZMJG, i_SZMXL, i_W, i_MA, i_WD,
        input  o_RD, o_RDV, o_BUSY, o_SEQERR, o_PERR
    );

    modport slave (
        input  i_SZMNC, i_SZMDL1, i_SZMDL2, i_SZMXT, i_SZMJG, i_SZMXL, i_W, i_MA, i_WD,
        output o_RD, o_RDV, o_BUSY, o_SEQERR, o_PERR
    );
endinterface

// File: rtl/core_mem_resp.sv
// Destructive-read core store driven by the memory-cycle timing strobes.
// Optional odd-parity array bit enabled with `define MEM_PARITY_EN.
module core_mem_resp #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_mem_resp_if.slave       bus,
    output logic [2:0]           dbg_state
);
    // Handshake: every strobe is a level; only its rising edge (registered level high,
    // delayed copy low) acts, one cycle after the level is first sampled.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] SENSE = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

`ifdef MEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    logic [MW-1:0] mem [0:(1<<AW)-1];

    logic [5:0]    stb_q, stb_d;
    logic [AW-1:0] ma_q, addr;
    logic          w_q, wr, dl2_seen;
    logic [DW-1:0] wd_q, rd;
    logic [MW-1:0] mb;
    logic [2:0]    state;
    logic          rdv, seqerr;

    logic [5:0]    rise;
    logic [4:0]    srise, exp_mask;
    logic          hit, stray, nc_end, take;
    logic          mem_we;
    logic [MW-1:0] mem_wdata;
    logic [DW-1:0] restore_data;

    // Bit order {nc, xl, jg, xt, dl2, dl1}; data is registered alongside to stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_q <= '0;
            stb_d <= '0;
            ma_q  <= '0;
            w_q   <= 1'b0;
            wd_q  <= '0;
        end else begin
            stb_q <= {bus.i_SZMNC, bus.i_SZMXL, bus.i_SZMJG, bus.i_SZMXT,
                      bus.i_SZMDL2, bus.i_SZMDL1};
            stb_d <= stb_q;
            ma_q  <= bus.i_MA;
            w_q   <= bus.i_W;
            wd_q  <= bus.i_WD;
        end
    end

    always_comb begin
        rise  = stb_q & ~stb_d;
        srise = rise[4:0];
        exp_mask = 5'b00000;
        case (state)
            IDLE:    exp_mask = stb_q[5] ? 5'b00000 : 5'b00001;
            ADDR:    exp_mask = dl2_seen ? 5'b00100 : 5'b00010;
            SENSE:   exp_mask = 5'b01000;
            HOLD:    exp_mask = 5'b10000;
            default: exp_mask = 5'b00000;
        endcase
        hit    = |(srise & exp_mask);
        stray  = |(srise & ~exp_mask);
        nc_end = rise[5] && (state != IDLE);
        take   = hit && !nc_end;
    end

    always_comb begin
        restore_data = wr ? wd_q : mb[DW-1:0];
        mem_we       = 1'b0;
        mem_wdata    = '0;
        if (take && state == ADDR && dl2_seen) begin
            mem_we = 1'b1;
        end else if (take && state == HOLD) begin
            mem_we = 1'b1;
`ifdef MEM_PARITY_EN
            mem_wdata = {~^restore_data, restore_data};
`else
            mem_wdata = restore_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= mem_wdata;
    end

`ifdef MEM_PARITY_EN
    logic perr;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dl2_seen <= 1'b0;
            addr     <= '0;
            wr       <= 1'b0;
            mb       <= '0;
            rd       <= '0;
            rdv      <= 1'b0;
            seqerr   <= 1'b0;
`ifdef MEM_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            rdv <= 1'b0;
`ifdef MEM_PARITY_EN
            perr <= 1'b0;
`endif
            if (nc_end) begin
                // Envelope closing outside DONE abandons the access without restore.
                state  <= IDLE;
                seqerr <= (state != DONE) || (|srise);
            end else begin
                seqerr <= stray;
                if (hit) begin
                    case (state)
                        IDLE: begin
                            state    <= ADDR;
                            addr     <= ma_q;
                            wr       <= w_q;
                            dl2_seen <= 1'b0;
                        end
                        ADDR: begin
                            if (!dl2_seen) begin
                                dl2_seen <= 1'b1;
                            end else begin
                                state <= SENSE;
                                mb    <= mem[addr];
                            end
                        end
                        SENSE: begin
                            state <= HOLD;
                            rd    <= mb[DW-1:0];
                            rdv   <= 1'b1;
`ifdef MEM_PARITY_EN
                            perr  <= ~^mb;
`endif
                        end
                        HOLD:    state <= DONE;
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    assign bus.o_RD     = rd;
    assign bus.o_RDV    = rdv;
    assign bus.o_SEQERR = seqerr;
    assign bus.o_BUSY   = (state != IDLE);
`ifdef MEM_PARITY_EN
    assign bus.o_PERR   = perr;
`else
    assign bus.o_PERR   = 1'b0;
`endif
    assign dbg_state    = state;
endmodule

// File: tb/tb_core_mem_resp.sv
// Directed bench for core_mem_resp: write/read, abort, order errors, reset mid-cycle,
// and the parity path when MEM_PARITY_EN is defined.
module tb_core_mem_resp;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] DL1  = 5'b00001;
  localparam logic [4:0] DL2  = 5'b00010;
  localparam logic [4:0] XT   = 5'b00100;
  localparam logic [4:0] JG   = 5'b01000;
  localparam logic [4:0] XL   = 5'b10000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_mem_resp_if #(.AW(AW), .DW(DW)) bus ();
  logic [2:0] dbg_state;

  core_mem_resp #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int seqerr_cnt = 0;
  int rdv_cnt = 0;
  int perr_cnt = 0;
  int perr_rdv_cnt = 0;
  int s0;
  int r0;
  // Expected read data; bit DW set means the value matters.
  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard / pulse monitor, sampled 1 time unit after each active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.o_SEQERR) seqerr_cnt++;
      if (bus.o_PERR) begin
        perr_cnt++;
        if (bus.o_RDV) perr_rdv_cnt++;
      end
      if (bus.o_RDV) begin
        rdv_cnt++;
        if (exp_q.size() == 0) begin
          check("rdv_spurious", 32'd1, 32'd0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if (e[DW]) check("rd_data", 32'(bus.o_RD), 32'(e[DW-1:0]));
        end
      end
    end
  end

  // driver: call at a negedge; strobe high for one cycle, returns two negedges later
  task automatic step(input logic nc, input logic [4:0] stb);
    bus.i_SZMNC = nc;
    {bus.i_SZMXL, bus.i_SZMJG, bus.i_SZMXT, bus.i_SZMDL2, bus.i_SZMDL1} = stb;
    @(negedge clk);
    {bus.i_SZMXL, bus.i_SZMJG, bus.i_SZMXT, bus.i_SZMDL2, bus.i_SZMDL1} = NONE;
    @(negedge clk);
  endtask

  task automatic run_cycle(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                           input logic [DW:0] exp_rd);
    bus.i_MA = a;
    bus.i_W  = w;
    bus.i_WD = wd;
    exp_q.push_back(exp_rd);
    step(1'b0, NONE);
    step(1'b0, DL1);
    step(1'b0, DL2);
    step(1'b0, XT);
    step(1'b0, JG);
    step(1'b0, XL);
    step(1'b1, NONE);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_SZMNC = 1'b1;
    {bus.i_SZMXL, bus.i_SZMJG, bus.i_SZMXT, bus.i_SZMDL2, bus.i_SZMDL1} = NONE;
    bus.i_W = 1'b0;
    bus.i_MA = '0;
    bus.i_WD = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", 32'(bus.o_RD), 32'd0);
    check("rst_rdv", 32'(bus.o_RDV), 32'd0);
    check("rst_busy", 32'(bus.o_BUSY), 32'd0);
    check("rst_seqerr", 32'(bus.o_SEQERR), 32'd0);
    check("rst_perr", 32'(bus.o_PERR), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write 0xBEEF to 0x005; word was never written so sensed data is a don't-care
    s0 = seqerr_cnt; r0 = rdv_cnt;
    bus.i_MA = 12'h005; bus.i_W = 1'b1; bus.i_WD = 16'hBEEF;
    exp_q.push_back('0);
    step(1'b0, NONE);
    step(1'b0, DL1);
    check("wr_busy", 32'(bus.o_BUSY), 32'd1);
    check("wr_state_addr", 32'(dbg_state), 32'd1);
    step(1'b0, DL2);
    step(1'b0, XT);
    step(1'b0, JG);
    step(1'b0, XL);
    check("wr_state_done", 32'(dbg_state), 32'd4);
    step(1'b1, NONE);
    check("wr_state_idle", 32'(dbg_state), 32'd0);
    check("wr_rdv_once", 32'(rdv_cnt - r0), 32'd1);
    check("wr_no_seqerr", 32'(seqerr_cnt - s0), 32'd0);

    // read back with explicit latency check around JG
    bus.i_MA = 12'h005; bus.i_W = 1'b0;
    exp_q.push_back({1'b1, 16'hBEEF});
    step(1'b0, NONE);
    step(1'b0, DL1);
    step(1'b0, DL2);
    step(1'b0, XT);
    bus.i_SZMJG = 1'b1;
    @(negedge clk);
    check("rdv_early", 32'(bus.o_RDV), 32'd0);
    bus.i_SZMJG = 1'b0;
    @(negedge clk);
    check("rdv_latency", 32'(bus.o_RDV), 32'd1);
    check("rd_latency", 32'(bus.o_RD), 32'hBEEF);
    @(negedge clk);
    check("rdv_pulse", 32'(bus.o_RDV), 32'd0);
    check("rd_hold", 32'(bus.o_RD), 32'hBEEF);
    step(1'b0, XL);
    step(1'b1, NONE);
    run_cycle(12'h005, 1'b0, 16'h0000, {1'b1, 16'hBEEF});

    // abort after JG: word stays destroyed
    s0 = seqerr_cnt;
    bus.i_MA = 12'h005; bus.i_W = 1'b0;
    exp_q.push_back({1'b1, 16'hBEEF});
    step(1'b0, NONE);
    step(1'b0, DL1);
    step(1'b0, DL2);
    step(1'b0, XT);
    step(1'b0, JG);
    step(1'b1, NONE);
    check("abort_seqerr", 32'(seqerr_cnt - s0), 32'd1);
    check("abort_idle", 32'(dbg_state), 32'd0);
    run_cycle(12'h005, 1'b0, 16'h0000, {1'b1, 16'h0000});

    // XT before DL2 is rejected, then the cycle proceeds
    run_cycle(12'h007, 1'b1, 16'h1234, '0);
    s0 = seqerr_cnt;
    bus.i_MA = 12'h007; bus.i_W = 1'b0;
    exp_q.push_back({1'b1, 16'h1234});
    step(1'b0, NONE);
    step(1'b0, DL1);
    step(1'b0, XT);
    check("order_seqerr", 32'(seqerr_cnt - s0), 32'd1);
    check("order_state", 32'(dbg_state), 32'd1);
    step(1'b0, DL2);
    step(1'b0, XT);
    check("order_sense", 32'(dbg_state), 32'd2);
    step(1'b0, JG);
    step(1'b0, XL);
    step(1'b1, NONE);
    check("order_total_seqerr", 32'(seqerr_cnt - s0), 32'd1);

    // stray strobes while idle
    s0 = seqerr_cnt;
    step(1'b1, JG);
    step(1'b1, DL1);
    check("idle_stray_seqerr", 32'(seqerr_cnt - s0), 32'd2);
    check("idle_stray_state", 32'(dbg_state), 32'd0);

    // reset while in HOLD
    bus.i_MA = 12'h005; bus.i_W = 1'b0;
    exp_q.push_back({1'b1, 16'h0000});
    step(1'b0, NONE);
    step(1'b0, DL1);
    step(1'b0, DL2);
    step(1'b0, XT);
    step(1'b0, JG);
    check("hold_state", 32'(dbg_state), 32'd3);
    bus.i_SZMNC = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("hrst_rd", 32'(bus.o_RD), 32'd0);
    check("hrst_busy", 32'(bus.o_BUSY), 32'd0);
    check("hrst_rdv", 32'(bus.o_RDV), 32'd0);
    check("hrst_seqerr", 32'(bus.o_SEQERR), 32'd0);
    check("hrst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    s0 = seqerr_cnt;
    run_cycle(12'h00A, 1'b1, 16'hA5C3, '0);
    run_cycle(12'h00A, 1'b0, 16'h0000, {1'b1, 16'hA5C3});
    check("post_rst_seqerr", 32'(seqerr_cnt - s0), 32'd0);

`ifdef MEM_PARITY_EN
    run_cycle(12'h005, 1'b1, 16'hBEEF, '0);
    s0 = perr_cnt; r0 = perr_rdv_cnt;
    dut.mem[5][DW] = ~dut.mem[5][DW];
    run_cycle(12'h005, 1'b0, 16'h0000, {1'b1, 16'hBEEF});
    check("perr_pulse", 32'(perr_cnt - s0), 32'd1);
    check("perr_with_rdv", 32'(perr_rdv_cnt - r0), 32'd1);
    s0 = perr_cnt;
    run_cycle(12'h005, 1'b0, 16'h0000, {1'b1, 16'hBEEF});
    check("perr_repaired", 32'(perr_cnt - s0), 32'd0);
`else
    check("perr_tied", 32'(perr_cnt), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
